// File: rtl/multicycle_pkg.sv
// Shared constants for the RV32I multicycle sequencer: state encodings,
// default opcodes, ALU operation codes and the opcode class record.
package multicycle_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic r;
        logic imm;
        logic load;
        logic store;
        logic branch;
        logic illegal;
    } opclass_t;

endpackage

// File: rtl/multicycle_control_opclass_decode.sv
// Combinational opcode classifier: one-hot {r, imm, load, store, branch, illegal}.
module opclass_decode
    import multicycle_pkg::*;
#(
    parameter logic [6:0] OP_R      = OPC_R,
    parameter logic [6:0] OP_LOAD   = OPC_LOAD,
    parameter logic [6:0] OP_STORE  = OPC_STORE,
    parameter logic [6:0] OP_BRANCH = OPC_BRANCH,
    parameter logic [6:0] OP_IMM    = OPC_IMM
) (
    input  logic [6:0] opcode,
    output opclass_t   opclass
);

    always_comb begin
        opclass = '0;
        case (opcode)
            OP_R:      opclass.r       = 1'b1;
            OP_IMM:    opclass.imm     = 1'b1;
            OP_LOAD:   opclass.load    = 1'b1;
            OP_STORE:  opclass.store   = 1'b1;
            OP_BRANCH: opclass.branch  = 1'b1;
            default:   opclass.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Optional: define ILLEGAL_TRAP_EN to trap unknown opcodes (adds port illegal).
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter logic [6:0] OP_R      = OPC_R,
    parameter logic [6:0] OP_LOAD   = OPC_LOAD,
    parameter logic [6:0] OP_STORE  = OPC_STORE,
    parameter logic [6:0] OP_BRANCH = OPC_BRANCH,
    parameter logic [6:0] OP_IMM    = OPC_IMM
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] opcode,
    input  logic       memready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       irwrite,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       alusrc,
    output logic       regwrite,
    output logic       branch,
    output logic [1:0] aluop,
    output logic       instdone,
    output logic [2:0] state
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    logic [2:0] state_d;
    logic [6:0] opreg;
    opclass_t   dec_cls;
    opclass_t   reg_cls;

    // DECODE classifies the live opcode; later states use the latched copy.
    opclass_decode #(
        .OP_R(OP_R), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE),
        .OP_BRANCH(OP_BRANCH), .OP_IMM(OP_IMM)
    ) u_dec_live (
        .opcode  (opcode),
        .opclass (dec_cls)
    );

    opclass_decode #(
        .OP_R(OP_R), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE),
        .OP_BRANCH(OP_BRANCH), .OP_IMM(OP_IMM)
    ) u_dec_reg (
        .opcode  (opreg),
        .opclass (reg_cls)
    );

    // NOTE: reset is sampled on the clock edge and state uses non-blocking
    // assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            opreg <= '0;
        end else begin
            state <= state_d;
            if (state == S_DECODE) opreg <= opcode;
        end
    end

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        irwrite     = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        alusrc      = 1'b0;
        regwrite    = 1'b0;
        branch      = 1'b0;
        aluop       = ALUOP_ADD;
        instdone    = 1'b0;

        case (state)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                memread = 1'b1;
                if (memready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_cls.illegal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    instdone = 1'b1;
                    state_d  = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (reg_cls.r) begin
                    aluop   = ALUOP_FUNCT;
                    state_d = S_WB;
                end else if (reg_cls.imm) begin
                    alusrc  = 1'b1;
                    state_d = S_WB;
                end else if (reg_cls.load || reg_cls.store) begin
                    alusrc  = 1'b1;
                    state_d = S_MEM;
                end else if (reg_cls.branch) begin
                    aluop       = ALUOP_SUB;
                    branch      = 1'b1;
                    pcwritecond = 1'b1;
                    instdone    = 1'b1;
                end
            end
            S_MEM: begin
                iord     = 1'b1;
                alusrc   = 1'b1;
                memread  = reg_cls.load;
                memwrite = reg_cls.store;
                if (memready) begin
                    if (reg_cls.load) begin
                        state_d = S_WB;
                    end else begin
                        instdone = reg_cls.store;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = reg_cls.load;
                instdone = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:  state_d = S_TRAP;
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state == S_TRAP);
`endif

endmodule
